// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the memory port.
// slave: arbiter view; master: environment (requesters + memory) view.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned INSN_W = 32;

    // I-side
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_valid;
    logic [INSN_W-1:0] iresp_data;

    // D-side
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic              dreq_write;
    logic [2:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_wdata;
    logic              dresp_valid;
    logic [DATA_W-1:0] dresp_data;

    // Memory port
    logic              mreq_valid;
    logic [ADDR_W-1:0] mreq_addr;
    logic              mreq_write;
    logic [2:0]        mreq_size;
    logic [7:0]        mreq_strobe;
    logic [DATA_W-1:0] mreq_wdata;
    logic              mresp_ready;
    logic [DATA_W-1:0] mresp_data;

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_valid, iresp_data,
        input  dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
        output dresp_valid, dresp_data,
        output mreq_valid, mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_wdata,
        input  mresp_ready, mresp_data
    );

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_valid, iresp_data,
        output dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
        input  dresp_valid, dresp_data,
        input  mreq_valid, mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_wdata,
        output mresp_ready, mresp_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the LSU.
// D-side has fixed priority; one transaction in flight, response routed back to
// the owner in the completion cycle. Optional I-side anti-starvation guard is
// enabled by defining ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);
    localparam int unsigned INSN_W = 32;
    localparam int unsigned CNT_W  = 4;

    // Guard counter is 4 bits wide, so the limit must fit 1..15.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_bus_arbiter: STARVE_LIMIT must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state;
    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic              write_r;
    logic [2:0]        size_r;
    logic [7:0]        strobe_r;
    logic [DATA_W-1:0] wdata_r;

    logic grant_d_c;
    logic grant_i_c;

`ifdef ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;

    // D wins unless the I-side has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_d_c = bus.dreq_valid;
        if (bus.ireq_valid && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
            grant_d_c = 1'b0;
        end
        grant_i_c = !grant_d_c && bus.ireq_valid;
    end

    // Count D wins that kept a waiting fetch out; any I grant restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_i_c) begin
                starve_cnt <= '0;
            end else if (grant_d_c && bus.ireq_valid) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Pure fixed D-side priority.
    always_comb begin
        grant_d_c = bus.dreq_valid;
        grant_i_c = !bus.dreq_valid && bus.ireq_valid;
    end
`endif

    // Grant FSM: capture the winner's request on the grant edge, hold until completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            valid_r  <= 1'b0;
            addr_r   <= '0;
            write_r  <= 1'b0;
            size_r   <= 3'd0;
            strobe_r <= 8'h00;
            wdata_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d_c) begin
                        state    <= BUSY_D;
                        valid_r  <= 1'b1;
                        addr_r   <= ADDR_W'(bus.dreq_addr);
                        write_r  <= bus.dreq_write;
                        size_r   <= bus.dreq_size;
                        strobe_r <= bus.dreq_strobe;
                        wdata_r  <= DATA_W'(bus.dreq_wdata);
                    end else if (grant_i_c) begin
                        state    <= BUSY_I;
                        valid_r  <= 1'b1;
                        addr_r   <= ADDR_W'(bus.ireq_addr);
                        write_r  <= 1'b0;
                        size_r   <= 3'd2;
                        strobe_r <= 8'h00;
                        wdata_r  <= DATA_W'(0);
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mresp_ready) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mreq_valid  = valid_r;
    assign bus.mreq_addr   = addr_r;
    assign bus.mreq_write  = write_r;
    assign bus.mreq_size   = size_r;
    assign bus.mreq_strobe = strobe_r;
    assign bus.mreq_wdata  = wdata_r;

    // Completion is forwarded in the same cycle; the fetch word is picked by the latched addr[2].
    assign bus.iresp_valid = (state == BUSY_I) && bus.mresp_ready;
    assign bus.dresp_valid = (state == BUSY_D) && bus.mresp_ready;
    assign bus.dresp_data  = bus.mresp_data;
    assign bus.iresp_data  = addr_r[2] ? bus.mresp_data[2*INSN_W-1 -: INSN_W]
                                       : bus.mresp_data[INSN_W-1:0];
endmodule
